// File: rtl/uart_rx_frontend.sv
// rtl/uart_rx_frontend.sv - 16x oversampling UART receiver with glitch rejection and one-byte holding register
// Optional even-parity bit and sticky parity_err output when UART_RX_PARITY_EN is defined.
module uart_rx_frontend #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 9600
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       UART_RX,
  input  logic       err_clr,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       rx_busy
);
  localparam int DIV = CLK_HZ / (BAUD * 16);
  localparam int DW  = $clog2(DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync2_q;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]    os_q, os_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          fe_q, fe_d;
  logic          ov_q, ov_d;
  logic          rxs, tick, deliver, fe_set, ov_set;
`ifdef UART_RX_PARITY_EN
  logic          par_bad_q, par_bad_d;
  logic          pe_q, pe_d;
  logic          pe_set;
`endif

  assign rxs  = sync2_q;
  assign tick = (div_q == DIV_MAX);

  always_ff @(posedge sysclk) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= S_IDLE;
      div_q     <= '0;
      os_q      <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      pe_q      <= 1'b0;
`endif
    end else begin
      sync1_q   <= UART_RX;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      div_q     <= div_d;
      os_q      <= os_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      pe_q      <= pe_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = tick ? '0 : div_q + DW'(1);
    os_d    = tick ? os_q + 4'd1 : os_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    deliver = 1'b0;
    fe_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    pe_set    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          state_d = S_START;
          div_d   = '0;
          os_d    = '0;
        end
      end
      S_START: begin
        // Mid start bit: a line back high means the low was a glitch.
        if (tick && os_q == 4'd7) begin
          if (rxs) begin
            state_d = S_IDLE;
          end else begin
            os_d    = '0;
            bit_d   = '0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (tick && os_q == 4'd15) begin
          shift_d[bit_q] = rxs;
          bit_d          = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick && os_q == 4'd15) begin
          par_bad_d = rxs ^ (^shift_q);
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (tick && os_q == 4'd15) begin
`ifdef UART_RX_PARITY_EN
          pe_set = par_bad_q;
`endif
          if (rxs) begin
            deliver = 1'b1;
            state_d = S_IDLE;
          end else begin
            fe_set  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Holding register: a delivery wins over ack, and ack in the delivery cycle frees the slot.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ov_set  = 1'b0;
    if (deliver) begin
      if (!valid_q || rx_ack) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ov_set = 1'b1;
      end
    end else if (rx_ack) begin
      valid_d = 1'b0;
    end
    fe_d = (fe_q & ~err_clr) | fe_set;
    ov_d = (ov_q & ~err_clr) | ov_set;
`ifdef UART_RX_PARITY_EN
    pe_d = (pe_q & ~err_clr) | pe_set;
`endif
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = fe_q;
  assign overrun   = ov_q;
  assign rx_busy   = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = pe_q;
`endif

endmodule
